// File: rtl/reg_bank_param.sv
// Parametrised RW/RO/W1C register bank with independent valid/ready read and write channels.
// Optional macro REG_BANK_PARAM_ERR_RESP_EN reports address misses on rack_err/wack_err.
module reg_bank_param #(
  parameter int                          ADDR_W    = 16,
  parameter int                          DATA_W    = 32,
  parameter int                          REG_NUM   = 8,
  parameter logic [ADDR_W-1:0]           BASE_ADDR = '0,
  parameter logic [REG_NUM-1:0]          RO_MASK   = '0,
  parameter logic [REG_NUM-1:0]          W1C_MASK  = '0,
  parameter logic [REG_NUM*DATA_W-1:0]   RST_VAL   = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_W-1:0]              rreq_addr,
  input  logic                           rreq_vld,
  output logic                           rreq_rdy,
  output logic [DATA_W-1:0]              rack_data,
  output logic                           rack_err,
  output logic                           rack_vld,
  input  logic                           rack_rdy,
  input  logic [ADDR_W-1:0]              wreq_addr,
  input  logic [DATA_W-1:0]              wreq_data,
  input  logic [DATA_W/8-1:0]            wreq_strb,
  input  logic                           wreq_vld,
  output logic                           wreq_rdy,
  output logic                           wack_err,
  output logic                           wack_vld,
  input  logic                           wack_rdy,
  input  logic [REG_NUM*DATA_W-1:0]      hw_rdat,
  input  logic [REG_NUM*DATA_W-1:0]      hw_set,
  output logic [REG_NUM*DATA_W-1:0]      reg_q,
  output logic [REG_NUM-1:0]             reg_wr_pulse
);

  localparam int                STRB_W = DATA_W / 8;
  localparam int                IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [ADDR_W:0]   NUM_A  = (ADDR_W+1)'(REG_NUM);

  logic [DATA_W-1:0]  regs_q [REG_NUM];
  logic [DATA_W-1:0]  regs_d [REG_NUM];
  logic [DATA_W-1:0]  rd_view [REG_NUM];
  logic [DATA_W-1:0]  rack_data_q, rack_data_d;
  logic               rack_vld_q, rack_vld_d;
  logic               rack_err_q, rack_err_d;
  logic               wack_vld_q, wack_vld_d;
  logic               wack_err_q, wack_err_d;
  logic [REG_NUM-1:0] wr_pulse_q, wr_pulse_d;

  logic [ADDR_W-1:0]  r_off, w_off;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic               r_hit, w_hit, rd_acc, wr_acc;
  logic [DATA_W-1:0]  strb_mask;
  logic [REG_NUM-1:0] wsel;

  // Offset wraps in ADDR_W bits; the >= BASE_ADDR test rejects wrapped low addresses.
  assign r_off  = rreq_addr - BASE_ADDR;
  assign w_off  = wreq_addr - BASE_ADDR;
  assign r_hit  = (rreq_addr >= BASE_ADDR) && ({1'b0, r_off} < NUM_A);
  assign w_hit  = (wreq_addr >= BASE_ADDR) && ({1'b0, w_off} < NUM_A);
  assign r_idx  = r_off[IDX_W-1:0];
  assign w_idx  = w_off[IDX_W-1:0];

  assign rreq_rdy = !rack_vld_q || rack_rdy;
  assign wreq_rdy = !wack_vld_q || wack_rdy;
  assign rd_acc   = rreq_vld && rreq_rdy;
  assign wr_acc   = wreq_vld && wreq_rdy;

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < STRB_W; b++) strb_mask[b*8 +: 8] = {8{wreq_strb[b]}};
    wsel = '0;
    if (wr_acc && w_hit) wsel[w_idx] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      rd_view[i] = RO_MASK[i] ? hw_rdat[i*DATA_W +: DATA_W] : regs_q[i];
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end else if (W1C_MASK[i]) begin
        // Set is OR'ed after the clear so a coincident set wins.
        regs_d[i] = (regs_q[i] & ~({DATA_W{wsel[i]}} & wreq_data & strb_mask))
                    | hw_set[i*DATA_W +: DATA_W];
      end else if (wsel[i]) begin
        regs_d[i] = (regs_q[i] & ~strb_mask) | (wreq_data & strb_mask);
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  always_comb begin
    rack_vld_d  = rd_acc || (rack_vld_q && !rack_rdy);
    rack_data_d = rack_data_q;
    if (rd_acc) rack_data_d = r_hit ? rd_view[r_idx] : '0;
    wack_vld_d  = wr_acc || (wack_vld_q && !wack_rdy);
    wr_pulse_d  = wsel & ~RO_MASK;
`ifdef REG_BANK_PARAM_ERR_RESP_EN
    rack_err_d  = rd_acc ? !r_hit : rack_err_q;
    wack_err_d  = wr_acc ? !w_hit : wack_err_q;
`else
    rack_err_d  = 1'b0;
    wack_err_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++)
        regs_q[i] <= RO_MASK[i] ? '0 : RST_VAL[i*DATA_W +: DATA_W];
      rack_data_q <= '0;
      rack_vld_q  <= 1'b0;
      rack_err_q  <= 1'b0;
      wack_vld_q  <= 1'b0;
      wack_err_q  <= 1'b0;
      wr_pulse_q  <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
      rack_data_q <= rack_data_d;
      rack_vld_q  <= rack_vld_d;
      rack_err_q  <= rack_err_d;
      wack_vld_q  <= wack_vld_d;
      wack_err_q  <= wack_err_d;
      wr_pulse_q  <= wr_pulse_d;
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_regq
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign rack_data    = rack_data_q;
  assign rack_vld     = rack_vld_q;
  assign rack_err     = rack_err_q;
  assign wack_vld     = wack_vld_q;
  assign wack_err     = wack_err_q;
  assign reg_wr_pulse = wr_pulse_q;

endmodule
